// File: rtl/alu_op_sequencer.sv
// Multi-cycle instruction sequencer: latches one instruction, reads operands from an 8x8 register
// file, drives an external combinational ALU, and writes the result back (IDLE/READ/EXEC/WB).
module alu_op_sequencer (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic       in_load,
    input  logic [3:0] in_ctrl,
    input  logic [2:0] in_rx,
    input  logic [2:0] in_ry,
    input  logic [2:0] in_rw,
    input  logic [7:0] in_imm,
    output logic [3:0] alu_ctrl,
    output logic [7:0] alu_x,
    output logic [7:0] alu_y,
    input  logic [7:0] alu_out,
    input  logic       alu_carry,
    output logic       done,
    output logic [7:0] result,
    output logic       carry_flag,
    input  logic [2:0] dbg_addr,
    output logic [7:0] dbg_data
);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRead = 2'd1,
        StExec = 2'd2,
        StWb   = 2'd3
    } state_e;

    state_e      state_q;

    logic        load_q;
    logic [3:0]  ctrl_q;
    logic [2:0]  rx_q;
    logic [2:0]  ry_q;
    logic [2:0]  rw_q;
    logic [7:0]  imm_q;

    logic [7:0]  op_x_q;
    logic [7:0]  op_y_q;
    logic [3:0]  op_ctrl_q;
    logic [7:0]  res_q;
    logic        carry_q;
    logic [7:0]  result_q;
    logic        carry_flag_q;

    // Entry 0 is never written, but reads of r0 are forced to zero anyway.
    logic [7:0]  regs_q [8];

    logic [7:0]  rd_x;
    logic [7:0]  rd_y;

    always_comb begin
        rd_x     = 8'h00;
        rd_y     = 8'h00;
        dbg_data = 8'h00;
        if (rx_q != 3'd0) begin
            rd_x = regs_q[rx_q];
        end
        if (ry_q != 3'd0) begin
            rd_y = regs_q[ry_q];
        end
        if (dbg_addr != 3'd0) begin
            dbg_data = regs_q[dbg_addr];
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q      <= StIdle;
            load_q       <= 1'b0;
            ctrl_q       <= 4'h0;
            rx_q         <= 3'd0;
            ry_q         <= 3'd0;
            rw_q         <= 3'd0;
            imm_q        <= 8'h00;
            op_x_q       <= 8'h00;
            op_y_q       <= 8'h00;
            op_ctrl_q    <= 4'h0;
            res_q        <= 8'h00;
            carry_q      <= 1'b0;
            result_q     <= 8'h00;
            carry_flag_q <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                regs_q[i] <= 8'h00;
            end
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        load_q  <= in_load;
                        ctrl_q  <= in_ctrl;
                        rx_q    <= in_rx;
                        ry_q    <= in_ry;
                        rw_q    <= in_rw;
                        imm_q   <= in_imm;
                        state_q <= StRead;
                    end
                end
                StRead: begin
                    if (load_q) begin
                        // A load is an ADD of the immediate and zero through the ALU.
                        op_x_q    <= imm_q;
                        op_y_q    <= 8'h00;
                        op_ctrl_q <= 4'b0000;
                    end else begin
                        op_x_q    <= rd_x;
                        op_y_q    <= rd_y;
                        op_ctrl_q <= ctrl_q;
                    end
                    state_q <= StExec;
                end
                StExec: begin
                    res_q   <= alu_out;
                    carry_q <= alu_carry;
                    state_q <= StWb;
                end
                StWb: begin
                    if (rw_q != 3'd0) begin
                        regs_q[rw_q] <= res_q;
                    end
                    result_q     <= res_q;
                    carry_flag_q <= carry_q;
                    state_q      <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign in_ready   = (state_q == StIdle);
    assign done       = (state_q == StWb);
    assign alu_x      = op_x_q;
    assign alu_y      = op_y_q;
    assign alu_ctrl   = op_ctrl_q;
    assign result     = result_q;
    assign carry_flag = carry_flag_q;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Scoreboard bench for alu_op_sequencer with a small behavioural ALU on the downstream side.
module tb_alu_op_sequencer;

    logic       Clk = 1'b0;
    logic       Reset;
    logic       in_valid;
    logic       in_ready;
    logic       in_load;
    logic [3:0] in_ctrl;
    logic [2:0] in_rx, in_ry, in_rw;
    logic [7:0] in_imm;
    logic [3:0] alu_ctrl;
    logic [7:0] alu_x, alu_y, alu_out;
    logic       alu_carry;
    logic       done;
    logic [7:0] result;
    logic       carry_flag;
    logic [2:0] dbg_addr;
    logic [7:0] dbg_data;

    localparam logic [3:0] OpAdd = 4'b0000;
    localparam logic [3:0] OpSub = 4'b0001;
    localparam logic [3:0] OpAnd = 4'b0010;
    localparam logic [3:0] OpEq  = 4'b1100;

    int errors = 0;
    int checks = 0;
    int cyc = 0;

    typedef struct {
        logic [7:0] res;
        logic       c;
        int         done_cyc;
    } exp_t;
    exp_t sb[$];

    always #5 Clk = ~Clk;
    always @(posedge Clk) cyc <= cyc + 1;

    alu_op_sequencer dut (
        .Clk        (Clk),
        .Reset      (Reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_load    (in_load),
        .in_ctrl    (in_ctrl),
        .in_rx      (in_rx),
        .in_ry      (in_ry),
        .in_rw      (in_rw),
        .in_imm     (in_imm),
        .alu_ctrl   (alu_ctrl),
        .alu_x      (alu_x),
        .alu_y      (alu_y),
        .alu_out    (alu_out),
        .alu_carry  (alu_carry),
        .done       (done),
        .result     (result),
        .carry_flag (carry_flag),
        .dbg_addr   (dbg_addr),
        .dbg_data   (dbg_data)
    );

    // Reference ALU: carry is the ninth sum bit for ADD and the borrow for SUB.
    always_comb begin
        logic [8:0] t;
        t = 9'h000;
        case (alu_ctrl)
            OpAdd:   t = {1'b0, alu_x} + {1'b0, alu_y};
            OpSub:   t = {1'b0, alu_x} - {1'b0, alu_y};
            OpAnd:   t = {1'b0, alu_x & alu_y};
            OpEq:    t = {8'h00, alu_x == alu_y};
            default: t = 9'h000;
        endcase
        alu_out   = t[7:0];
        alu_carry = t[8];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge Clk) begin
        if (done === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("done_latency", cyc, e.done_cyc);
                @(negedge Clk);
                chk("done_single_cycle", {31'd0, done}, 32'd0);
                chk("result", {24'd0, result}, {24'd0, e.res});
                chk("carry_flag", {31'd0, carry_flag}, {31'd0, e.c});
            end
        end
    end

    // Presents an instruction (leaving in_valid high) and returns at the negedge after acceptance.
    task automatic issue(input logic ld, input logic [3:0] ctrl, input logic [2:0] rx,
                         input logic [2:0] ry, input logic [2:0] rw, input logic [7:0] imm,
                         input logic [7:0] er, input logic ec, input bit track,
                         output int acc_edge, output int busy);
        bit found;
        exp_t e;
        found    = 0;
        busy     = 0;
        in_valid = 1'b1;
        in_load  = ld;
        in_ctrl  = ctrl;
        in_rx    = rx;
        in_ry    = ry;
        in_rw    = rw;
        in_imm   = imm;
        for (int i = 0; i < 20; i++) begin
            if (in_ready === 1'b1) begin
                found = 1;
                break;
            end
            busy++;
            @(negedge Clk);
        end
        if (!found) chk("accept_timeout", 32'd0, 32'd1);
        acc_edge = cyc + 1;
        if (track) begin
            e.res      = er;
            e.c        = ec;
            e.done_cyc = acc_edge + 2;
            sb.push_back(e);
        end
        @(negedge Clk);
    endtask

    task automatic drain();
        for (int i = 0; i < 20; i++) begin
            if (sb.size() == 0 && in_ready === 1'b1) break;
            @(negedge Clk);
        end
        @(negedge Clk);
        @(negedge Clk);
    endtask

    task automatic chk_reg(input logic [2:0] a, input logic [7:0] exp);
        dbg_addr = a;
        #1;
        chk($sformatf("dbg_r%0d", a), {24'd0, dbg_data}, {24'd0, exp});
    endtask

    initial begin
        int a0, a1, b, dcount;
        Reset    = 1'b1;
        in_valid = 1'b1;
        in_load  = 1'b1;
        in_ctrl  = OpAdd;
        in_rx    = 3'd0;
        in_ry    = 3'd0;
        in_rw    = 3'd1;
        in_imm   = 8'hAA;
        dbg_addr = 3'd0;
        @(negedge Clk);
        @(negedge Clk);
        Reset    = 1'b0;
        in_valid = 1'b0;
        chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
        chk("reset_done", {31'd0, done}, 32'd0);
        chk("reset_result", {24'd0, result}, 32'd0);
        chk("reset_carry", {31'd0, carry_flag}, 32'd0);
        for (int i = 0; i < 8; i++) chk_reg(3'(i), 8'h00);
        @(negedge Clk);
        chk("no_accept_in_reset", {31'd0, in_ready}, 32'd1);

        // Load and add with carry out
        issue(1'b1, OpSub, 3'd2, 3'd3, 3'd1, 8'hF0, 8'hF0, 1'b0, 1'b1, a0, b);
        in_valid = 1'b0;
        drain();
        issue(1'b1, OpAdd, 3'd0, 3'd0, 3'd2, 8'h20, 8'h20, 1'b0, 1'b1, a0, b);
        in_valid = 1'b0;
        drain();
        issue(1'b0, OpAdd, 3'd1, 3'd2, 3'd3, 8'h00, 8'h10, 1'b1, 1'b1, a0, b);
        in_valid = 1'b0;
        drain();
        chk_reg(3'd3, 8'h10);

        // r0 stays zero; load produces carry 0
        issue(1'b1, OpAdd, 3'd0, 3'd0, 3'd0, 8'h55, 8'h55, 1'b0, 1'b1, a0, b);
        in_valid = 1'b0;
        drain();
        chk_reg(3'd0, 8'h00);
        issue(1'b0, OpAdd, 3'd0, 3'd1, 3'd4, 8'h00, 8'hF0, 1'b0, 1'b1, a0, b);
        in_valid = 1'b0;
        drain();
        chk_reg(3'd4, 8'hF0);

        // Dependency chain: 10 - 20 = F0 with borrow, then F0 & F0
        issue(1'b0, OpSub, 3'd3, 3'd2, 3'd6, 8'h00, 8'hF0, 1'b1, 1'b1, a0, b);
        in_valid = 1'b0;
        drain();
        issue(1'b0, OpAnd, 3'd6, 3'd1, 3'd7, 8'h00, 8'hF0, 1'b0, 1'b1, a0, b);
        in_valid = 1'b0;
        drain();
        chk_reg(3'd6, 8'hF0);
        chk_reg(3'd7, 8'hF0);

        // EQ with rx == ry, written over its own source
        issue(1'b0, OpEq, 3'd7, 3'd7, 3'd7, 8'h00, 8'h01, 1'b0, 1'b1, a0, b);
        in_valid = 1'b0;
        drain();
        chk_reg(3'd7, 8'h01);

        // Backpressure: second instruction held valid while the first is busy
        issue(1'b1, OpAdd, 3'd0, 3'd0, 3'd5, 8'h3C, 8'h3C, 1'b0, 1'b1, a0, b);
        issue(1'b0, OpAdd, 3'd5, 3'd2, 3'd2, 8'h00, 8'h5C, 1'b0, 1'b1, a1, b);
        in_valid = 1'b0;
        chk("bp_accept_spacing", a1 - a0, 32'd4);
        chk("bp_busy_cycles", b, 32'd3);
        drain();
        chk_reg(3'd5, 8'h3C);
        chk_reg(3'd2, 8'h5C);

        // Reset during EXEC aborts the instruction
        issue(1'b0, OpSub, 3'd1, 3'd2, 3'd5, 8'h00, 8'h00, 1'b0, 1'b0, a0, b);
        in_valid = 1'b0;
        @(negedge Clk);
        Reset = 1'b1;
        @(negedge Clk);
        Reset = 1'b0;
        chk("abort_in_ready", {31'd0, in_ready}, 32'd1);
        dcount = 0;
        for (int i = 0; i < 6; i++) begin
            if (done === 1'b1) dcount++;
            @(negedge Clk);
        end
        chk("abort_no_done", dcount, 32'd0);
        chk_reg(3'd5, 8'h00);
        chk_reg(3'd1, 8'h00);
        chk("abort_result", {24'd0, result}, 32'd0);
        chk("scoreboard_empty", sb.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL global_timeout: got cycle %0d expected completion", cyc);
        $fatal(1);
    end

endmodule

// File: doc/alu_op_sequencer.md
ALU_OP_SEQUENCER -- requirements
Module: alu_op_sequencer

Interface
REQ-001 The block SHALL have one clock, and its reset SHALL be synchronous and active-high.
REQ-002 Clk  in  1  system clock; all state SHALL update on its rising edge.
REQ-003 Reset  in  1  synchronous active-high reset, sampled on the rising edge of Clk.
REQ-004 in_valid  in  1  instruction request.
REQ-005 in_ready  out  1  block can accept an instruction; combinational, high only in IDLE.
REQ-006 in_load  in  1  1 = load immediate, 0 = ALU operation.
REQ-007 in_ctrl  in  4  ALU opcode, using the team ALU encoding (ADD = 4'b0000 ... EQ = 4'b1100).
REQ-008 in_rx, in_ry, in_rw  in  3 each  source X, source Y and destination register indices.
REQ-009 in_imm  in  8  immediate value for a load.
REQ-010 alu_ctrl  out  4  opcode sent to the downstream combinational ALU.
REQ-011 alu_x, alu_y  out  8 each  operands sent to the ALU.
REQ-012 alu_out  in  8  ALU result.
REQ-013 alu_carry  in  1  ALU carry.
REQ-014 done  out  1  high for exactly the one WB cycle of each instruction.
REQ-015 result  out  8  last written-back value.
REQ-016 carry_flag  out  1  last captured carry.
REQ-017 dbg_addr  in  3  debug read index.
REQ-018 dbg_data  out  8  combinational read of register[dbg_addr].

Function
REQ-019 The register file SHALL hold eight 8-bit registers r0..r7.
  - r0 SHALL always read 8'h00.
  - Writes to r0 SHALL be discarded.
REQ-020 The FSM SHALL have four states: IDLE -> READ -> EXEC -> WB -> IDLE. No other transitions are permitted except reset.
REQ-021 Accept rule: an instruction SHALL be accepted only on an edge where state == IDLE and in_valid == 1.
  - All in_* fields SHALL be latched on that edge.
  - Next state SHALL be READ.
REQ-022 IDLE with in_valid == 0 SHALL remain in IDLE.
REQ-023 While not in IDLE, the block SHALL ignore in_valid and all in_* fields; latched fields SHALL NOT change.
REQ-024 READ, ALU operation: on the exit edge, op_x <= reg[rx], op_y <= reg[ry], op_ctrl <= ctrl.
REQ-025 READ, load: on the exit edge, op_x <= imm, op_y <= 8'h00, op_ctrl <= 4'b0000 (ADD).
REQ-026 alu_x, alu_y and alu_ctrl SHALL be driven directly from the op_* registers and SHALL stay stable from EXEC through WB.
REQ-027 EXEC: on the exit edge, res_q <= alu_out and carry_q <= alu_carry.
REQ-028 WB:
  - done SHALL be 1.
  - On the exit edge, reg[rw] <= res_q (unless rw == 0), result <= res_q, carry_flag <= carry_q.
REQ-029 carry_flag SHALL update on every instruction, including loads (which produce carry 0) and writes aimed at r0.
REQ-030 Latency: done SHALL be high in the third cycle after the accept edge. Peak throughput SHALL be one instruction per 4 cycles.
REQ-031 Dependent instructions: READ SHALL see the prior instruction's write-back value; because instructions never overlap, no forwarding is required.
REQ-032 rx == ry SHALL read the same register into both operands.
REQ-033 rw equal to rx or ry SHALL overwrite that register only at the WB exit edge.
REQ-034 All arithmetic width and carry behaviour SHALL come from the ALU; the block SHALL NOT modify alu_out.

Reset
REQ-035 While Reset is high at an edge, the block SHALL set: state = IDLE; r1..r7 = 0; op_x = op_y = 0; op_ctrl = 0; res_q = 0; carry_q = 0; result = 0; carry_flag = 0.
REQ-036 In the cycle after reset, done SHALL be 0 and in_ready SHALL be 1.
REQ-037 Reset asserted in READ, EXEC or WB SHALL abort the instruction with no register write; reset SHALL take priority over the WB write on the same edge.
REQ-038 An instruction presented while Reset is high SHALL NOT be accepted.

Verification
REQ-039 Reset: hold Reset 2 cycles -> in_ready = 1, done = 0, result = 0, carry_flag = 0, dbg_data = 0 for dbg_addr 0..7.
REQ-040 Load and add: LOAD r1 = F0; LOAD r2 = 20; ADD r3 = r1 + r2 (real ALU) -> done 3 cycles after each accept; r3 = 10, result = 10, carry_flag = 1.
REQ-041 r0 protection: LOAD r0 = 55 -> done pulses once, dbg r0 = 00, result = 55; next ADD r4 = r0 + r1 -> r4 = F0.
REQ-042 Busy backpressure: hold in_valid = 1 with two different instructions -> the second is accepted on exactly the edge after the first one's WB; no instruction is lost or duplicated; in_ready = 0 for 3 cycles per instruction.
REQ-043 Reset mid-operation: assert Reset in EXEC of SUB r5 = r1 - r2 -> r5 unchanged (00), done never asserts, in_ready = 1 the next cycle.
REQ-044 Dependency chain: after REQ-040, SUB r6 = r3 - r2, then AND r7 = r6 & r1 -> r6 = F0, r7 = F0.
